// File: rtl/bridge_master.sv
// bridge_master
//   Terminates NoC requests from a remote bridge_slave. Each request is turned
//   into one AXI-light master transaction towards the local slave, and one
//   response packet then goes back to the requesting node. Only one
//   transaction is outstanding at a time.
//
// Ports
//   clk, res_n                  clock, asynchronous active-low reset
//   noc_req_*                   request packet in (valid/ready, src, we, addr, wdata, wstrb)
//   noc_rsp_*                   response packet out (valid/ready, dst, src, we, rdata, err)
//   m_aw*, m_w*, m_b*           AXI-light write address / data / response channels
//   m_ar*, m_r*                 AXI-light read address / data channels
//   busy                        high whenever a transaction is in progress
//   txn_count                   number of completed responses (wraps)
module bridge_master #(
   parameter int ID         = 0,
   parameter int SRC_WIDTH  = 8,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    res_n,
   input  logic                    noc_req_valid,
   output logic                    noc_req_ready,
   input  logic [SRC_WIDTH-1:0]    noc_req_src,
   input  logic                    noc_req_we,
   input  logic [ADDR_WIDTH-1:0]   noc_req_addr,
   input  logic [DATA_WIDTH-1:0]   noc_req_wdata,
   input  logic [DATA_WIDTH/8-1:0] noc_req_wstrb,
   output logic                    noc_rsp_valid,
   input  logic                    noc_rsp_ready,
   output logic [SRC_WIDTH-1:0]    noc_rsp_dst,
   output logic [SRC_WIDTH-1:0]    noc_rsp_src,
   output logic                    noc_rsp_we,
   output logic [DATA_WIDTH-1:0]   noc_rsp_rdata,
   output logic                    noc_rsp_err,
   output logic                    m_awvalid,
   input  logic                    m_awready,
   output logic [ADDR_WIDTH-1:0]   m_awaddr,
   output logic                    m_wvalid,
   input  logic                    m_wready,
   output logic [DATA_WIDTH-1:0]   m_wdata,
   output logic [DATA_WIDTH/8-1:0] m_wstrb,
   input  logic                    m_bvalid,
   output logic                    m_bready,
   input  logic [1:0]              m_bresp,
   output logic                    m_arvalid,
   input  logic                    m_arready,
   output logic [ADDR_WIDTH-1:0]   m_araddr,
   input  logic                    m_rvalid,
   output logic                    m_rready,
   input  logic [DATA_WIDTH-1:0]   m_rdata,
   input  logic [1:0]              m_rresp,
   output logic                    busy,
   output logic [31:0]             txn_count
);

   localparam int STRB_WIDTH = DATA_WIDTH / 8;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_WR      = 3'd1,
      S_WR_RESP = 3'd2,
      S_RD      = 3'd3,
      S_RD_DATA = 3'd4,
      S_RSP     = 3'd5
   } state_t;

   state_t                  state_q, state_d;
   logic [SRC_WIDTH-1:0]    src_q, src_d;
   logic                    we_q, we_d;
   logic [ADDR_WIDTH-1:2]   addr_q, addr_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic [STRB_WIDTH-1:0]   wstrb_q, wstrb_d;
   logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
   logic                    err_q, err_d;
   logic                    aw_done_q, aw_done_d;
   logic                    w_done_q, w_done_d;
   logic [31:0]             txn_count_q, txn_count_d;

   logic aw_ok;
   logic w_ok;

   // Byte-offset bits of the address and the low response bit carry no
   // information for this bridge.
   logic unused_bits;
   assign unused_bits = ^{noc_req_addr[1:0], m_bresp[0], m_rresp[0]};

   // State register
   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         state_q     <= S_IDLE;
         src_q       <= '0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         rdata_q     <= '0;
         err_q       <= 1'b0;
         aw_done_q   <= 1'b0;
         w_done_q    <= 1'b0;
         txn_count_q <= '0;
      end else begin
         state_q     <= state_d;
         src_q       <= src_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         wstrb_q     <= wstrb_d;
         rdata_q     <= rdata_d;
         err_q       <= err_d;
         aw_done_q   <= aw_done_d;
         w_done_q    <= w_done_d;
         txn_count_q <= txn_count_d;
      end
   end

   // A write channel counts as finished if it completed earlier or is
   // completing this cycle; AW and W may finish in either order.
   assign aw_ok = aw_done_q | (m_awvalid & m_awready);
   assign w_ok  = w_done_q  | (m_wvalid  & m_wready);

   // Next-state logic
   always_comb begin
      state_d     = state_q;
      src_d       = src_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      wstrb_d     = wstrb_q;
      rdata_d     = rdata_q;
      err_d       = err_q;
      aw_done_d   = aw_done_q;
      w_done_d    = w_done_q;
      txn_count_d = txn_count_q;
      case (state_q)
         S_IDLE: begin
            if (noc_req_valid) begin
               src_d     = noc_req_src;
               we_d      = noc_req_we;
               addr_d    = noc_req_addr[ADDR_WIDTH-1:2];
               wdata_d   = noc_req_wdata;
               wstrb_d   = noc_req_wstrb;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               state_d   = noc_req_we ? S_WR : S_RD;
            end
         end
         S_WR: begin
            aw_done_d = aw_ok;
            w_done_d  = w_ok;
            if (aw_ok && w_ok) begin
               state_d = S_WR_RESP;
            end
         end
         S_WR_RESP: begin
            if (m_bvalid) begin
               rdata_d = '0;
               err_d   = m_bresp[1];
               state_d = S_RSP;
            end
         end
         S_RD: begin
            if (m_arready) begin
               state_d = S_RD_DATA;
            end
         end
         S_RD_DATA: begin
            if (m_rvalid) begin
               rdata_d = m_rdata;
               err_d   = m_rresp[1];
               state_d = S_RSP;
            end
         end
         S_RSP: begin
            if (noc_rsp_ready) begin
               txn_count_d = txn_count_q + 32'd1;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Output logic: every valid/ready is a function of registered state only,
   // so no valid ever depends combinationally on a ready.
   always_comb begin
      noc_req_ready = (state_q == S_IDLE);
      m_awvalid     = (state_q == S_WR) && !aw_done_q;
      m_wvalid      = (state_q == S_WR) && !w_done_q;
      m_bready      = (state_q == S_WR_RESP);
      m_arvalid     = (state_q == S_RD);
      m_rready      = (state_q == S_RD_DATA);
      noc_rsp_valid = (state_q == S_RSP);
      busy          = (state_q != S_IDLE);
   end

   assign m_awaddr      = {addr_q, 2'b00};
   assign m_araddr      = {addr_q, 2'b00};
   assign m_wdata       = wdata_q;
   assign m_wstrb       = wstrb_q;
   assign noc_rsp_dst   = src_q;
   assign noc_rsp_src   = SRC_WIDTH'(ID);
   assign noc_rsp_we    = we_q;
   assign noc_rsp_rdata = rdata_q;
   assign noc_rsp_err   = err_q;
   assign txn_count     = txn_count_q;

endmodule

// File: tb/tb_bridge_master.sv
`timescale 1ns/1ps
module tb_bridge_master;
   localparam int ID = 'h5A;

   logic        clk = 1'b0;
   logic        res_n = 1'b0;
   logic        noc_req_valid, noc_req_ready;
   logic [7:0]  noc_req_src;
   logic        noc_req_we;
   logic [31:0] noc_req_addr, noc_req_wdata;
   logic [3:0]  noc_req_wstrb;
   logic        noc_rsp_valid, noc_rsp_ready;
   logic [7:0]  noc_rsp_dst, noc_rsp_src;
   logic        noc_rsp_we;
   logic [31:0] noc_rsp_rdata;
   logic        noc_rsp_err;
   logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
   logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
   logic [3:0]  m_wstrb;
   logic [1:0]  m_bresp, m_rresp;
   logic        m_arvalid, m_arready, m_rvalid, m_rready;
   logic        busy;
   logic [31:0] txn_count;

   always #5 clk = ~clk;

   bridge_master #(.ID(ID), .SRC_WIDTH(8), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .clk(clk), .res_n(res_n),
      .noc_req_valid(noc_req_valid), .noc_req_ready(noc_req_ready),
      .noc_req_src(noc_req_src), .noc_req_we(noc_req_we), .noc_req_addr(noc_req_addr),
      .noc_req_wdata(noc_req_wdata), .noc_req_wstrb(noc_req_wstrb),
      .noc_rsp_valid(noc_rsp_valid), .noc_rsp_ready(noc_rsp_ready),
      .noc_rsp_dst(noc_rsp_dst), .noc_rsp_src(noc_rsp_src), .noc_rsp_we(noc_rsp_we),
      .noc_rsp_rdata(noc_rsp_rdata), .noc_rsp_err(noc_rsp_err),
      .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
      .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
      .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
      .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
      .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
      .busy(busy), .txn_count(txn_count)
   );

   typedef struct packed {
      logic [7:0]  src;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
   } req_t;

   int total = 0;
   int bad = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
      end
   endtask

   // Transaction-level model of the bridge
   req_t        req_q[$];
   req_t        cur;
   bit          act = 0;
   int          aw_n, w_n, ar_n;
   bit          b_done, r_done;
   logic [31:0] exp_rdata;
   logic        exp_err;
   logic [31:0] mcount = '0;
   bit          started = 0;

   // Slave / sink knobs
   bit          rand_mode = 0, junk_en = 0;
   int          aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0, r_dly = 0, rsp_dly = 0;
   logic [1:0]  b_resp_k = 2'b00, r_resp_k = 2'b00;
   logic [31:0] r_data_k = '0;
   int          aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt, rsp_cnt;

   // Observation log
   int          cyc = 0, req_n = 0, rsp_n = 0;
   int          req_cyc[512];
   int          rsp_cyc[512];
   int          first_rsp_cyc, last_hold, last_aw_cyc, last_w_cyc;
   bit          rsp_seen = 0;
   logic [31:0] last_awaddr, last_araddr, last_wdata, last_rdata;
   logic [3:0]  last_wstrb;
   logic [7:0]  last_dst, last_src;
   logic        last_we, last_err;
   int          last_aw_n, last_w_n;

   task automatic randomize_knobs();
      aw_dly   = int'($urandom % 4);
      w_dly    = int'($urandom % 4);
      ar_dly   = int'($urandom % 4);
      b_dly    = int'($urandom % 4);
      r_dly    = int'($urandom % 4);
      rsp_dly  = int'($urandom % 4);
      b_resp_k = 2'($urandom);
      r_resp_k = 2'($urandom);
      r_data_k = $urandom;
   endtask

   task automatic set_dly(input int aw, input int w, input int ar, input int b, input int r, input int rsp);
      aw_dly = aw; w_dly = w; ar_dly = ar; b_dly = b; r_dly = r; rsp_dly = rsp;
   endtask

   // Request source, AXI slave and response sink; model updated after each edge
   initial begin : driver
      bit          h_req, h_aw, h_w, h_ar, h_b, h_r, h_rsp;
      req_t        h_req_v;
      logic [1:0]  h_resp;
      logic [31:0] h_data;
      forever begin
         @(negedge clk);
         cyc++;
         h_req = 0; h_aw = 0; h_w = 0; h_ar = 0; h_b = 0; h_r = 0; h_rsp = 0;
         if (!res_n) begin
            aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0; rsp_cnt = 0;
            noc_req_valid = 0; noc_rsp_ready = 0;
            m_awready = 0; m_wready = 0; m_arready = 0; m_bvalid = 0; m_rvalid = 0;
            continue;
         end
         if (!noc_req_valid && req_q.size() > 0 && (!rand_mode || ($urandom % 3 != 0))) begin
            noc_req_valid = 1;
            noc_req_src   = req_q[0].src;
            noc_req_we    = req_q[0].we;
            noc_req_addr  = req_q[0].addr;
            noc_req_wdata = req_q[0].wdata;
            noc_req_wstrb = req_q[0].wstrb;
         end
         if (noc_req_valid && noc_req_ready) begin
            h_req = 1;
            h_req_v = req_q.pop_front();
            req_cyc[req_n] = cyc;
         end
         if (m_awvalid) begin m_awready = (aw_cnt >= aw_dly); aw_cnt++; end
         else begin aw_cnt = 0; m_awready = rand_mode ? 1'($urandom % 2) : 1'b0; end
         if (m_awvalid && m_awready) begin h_aw = 1; last_awaddr = m_awaddr; last_aw_cyc = cyc; end
         if (m_wvalid) begin m_wready = (w_cnt >= w_dly); w_cnt++; end
         else begin w_cnt = 0; m_wready = rand_mode ? 1'($urandom % 2) : 1'b0; end
         if (m_wvalid && m_wready) begin
            h_w = 1; last_wdata = m_wdata; last_wstrb = m_wstrb; last_w_cyc = cyc;
         end
         if (m_arvalid) begin m_arready = (ar_cnt >= ar_dly); ar_cnt++; end
         else begin ar_cnt = 0; m_arready = rand_mode ? 1'($urandom % 2) : 1'b0; end
         if (m_arvalid && m_arready) begin h_ar = 1; last_araddr = m_araddr; end
         if (m_bready) begin m_bvalid = (b_cnt >= b_dly); m_bresp = b_resp_k; b_cnt++; end
         else begin b_cnt = 0; m_bvalid = junk_en && ($urandom % 4 == 0); m_bresp = 2'($urandom); end
         if (m_bready && m_bvalid) begin h_b = 1; h_resp = m_bresp; end
         if (m_rready) begin
            m_rvalid = (r_cnt >= r_dly); m_rresp = r_resp_k; m_rdata = r_data_k; r_cnt++;
         end else begin
            r_cnt = 0; m_rvalid = junk_en && ($urandom % 4 == 0);
            m_rresp = 2'($urandom); m_rdata = $urandom;
         end
         if (m_rready && m_rvalid) begin h_r = 1; h_resp = m_rresp; h_data = m_rdata; end
         if (noc_rsp_valid) begin
            if (!rsp_seen) begin rsp_seen = 1; first_rsp_cyc = cyc; end
            noc_rsp_ready = (rsp_cnt >= rsp_dly); rsp_cnt++;
         end else begin
            rsp_cnt = 0; noc_rsp_ready = rand_mode ? 1'($urandom % 2) : 1'b0;
         end
         if (noc_rsp_valid && noc_rsp_ready) begin
            h_rsp = 1;
            last_dst = noc_rsp_dst; last_src = noc_rsp_src; last_we = noc_rsp_we;
            last_rdata = noc_rsp_rdata; last_err = noc_rsp_err;
            last_hold = cyc - first_rsp_cyc;
            rsp_cyc[rsp_n] = cyc;
         end
         @(posedge clk);
         #1;
         if (!res_n) continue;
         if (h_req) begin
            cur = h_req_v; act = 1;
            aw_n = 0; w_n = 0; ar_n = 0; b_done = 0; r_done = 0; rsp_seen = 0;
            noc_req_valid = 0;
            req_n++;
            if (rand_mode) randomize_knobs();
         end
         if (h_aw) aw_n++;
         if (h_w)  w_n++;
         if (h_ar) ar_n++;
         if (h_b) begin b_done = 1; exp_rdata = '0; exp_err = h_resp[1]; end
         if (h_r) begin r_done = 1; exp_rdata = h_data; exp_err = h_resp[1]; end
         if (h_rsp) begin
            act = 0; mcount = mcount + 1; last_aw_n = aw_n; last_w_n = w_n; rsp_n++;
         end
      end
   end

   // Per-cycle comparison of every DUT output against the model
   logic e_aw, e_w, e_b, e_ar, e_r, e_rsp;
   always @(negedge clk) begin
      if (started && res_n) begin
         e_aw  = act && cur.we && (aw_n == 0);
         e_w   = act && cur.we && (w_n == 0);
         e_b   = act && cur.we && (aw_n > 0) && (w_n > 0) && !b_done;
         e_ar  = act && !cur.we && (ar_n == 0);
         e_r   = act && !cur.we && (ar_n > 0) && !r_done;
         e_rsp = act && (cur.we ? b_done : r_done);
         chk("busy", 32'(busy), 32'(act));
         chk("req_ready", 32'(noc_req_ready), 32'(!act));
         chk("awvalid", 32'(m_awvalid), 32'(e_aw));
         chk("wvalid", 32'(m_wvalid), 32'(e_w));
         chk("bready", 32'(m_bready), 32'(e_b));
         chk("arvalid", 32'(m_arvalid), 32'(e_ar));
         chk("rready", 32'(m_rready), 32'(e_r));
         chk("rsp_valid", 32'(noc_rsp_valid), 32'(e_rsp));
         chk("txn_count", txn_count, mcount);
         if (e_aw) chk("awaddr", m_awaddr, cur.addr & 32'hFFFF_FFFC);
         if (e_ar) chk("araddr", m_araddr, cur.addr & 32'hFFFF_FFFC);
         if (e_w) begin
            chk("wdata", m_wdata, cur.wdata);
            chk("wstrb", 32'(m_wstrb), 32'(cur.wstrb));
         end
         if (e_rsp) begin
            chk("rsp_dst", 32'(noc_rsp_dst), 32'(cur.src));
            chk("rsp_src", 32'(noc_rsp_src), 32'(8'(ID)));
            chk("rsp_we", 32'(noc_rsp_we), 32'(cur.we));
            chk("rsp_rdata", noc_rsp_rdata, exp_rdata);
            chk("rsp_err", 32'(noc_rsp_err), 32'(exp_err));
         end
      end
   end

   task automatic send(input logic [7:0] src, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] wstrb);
      req_t r;
      r.src = src; r.we = we; r.addr = addr; r.wdata = wdata; r.wstrb = wstrb;
      req_q.push_back(r);
   endtask

   task automatic wait_rsp(input int target, input int limit, input string name);
      int k = 0;
      while (rsp_n < target && k < limit) begin
         @(negedge clk);
         k++;
      end
      chk(name, 32'(rsp_n), 32'(target));
   endtask

   task automatic chk_idle_outputs(input string pfx);
      chk({pfx, "_busy"}, 32'(busy), 32'd0);
      chk({pfx, "_awvalid"}, 32'(m_awvalid), 32'd0);
      chk({pfx, "_wvalid"}, 32'(m_wvalid), 32'd0);
      chk({pfx, "_bready"}, 32'(m_bready), 32'd0);
      chk({pfx, "_arvalid"}, 32'(m_arvalid), 32'd0);
      chk({pfx, "_rready"}, 32'(m_rready), 32'd0);
      chk({pfx, "_rsp_valid"}, 32'(noc_rsp_valid), 32'd0);
      chk({pfx, "_txn_count"}, txn_count, 32'd0);
   endtask

   initial begin : main
      int base, rq, k;
      logic [31:0] c0;
      noc_req_valid = 0; noc_req_src = '0; noc_req_we = 0; noc_req_addr = '0;
      noc_req_wdata = '0; noc_req_wstrb = '0; noc_rsp_ready = 0;
      m_awready = 0; m_wready = 0; m_arready = 0; m_bvalid = 0; m_rvalid = 0;
      m_bresp = '0; m_rresp = '0; m_rdata = '0;
      repeat (3) @(posedge clk);
      #1;
      chk_idle_outputs("reset");
      @(negedge clk);
      #2 res_n = 1;
      started = 1;

      // Write with AW delayed 3 cycles, W immediate
      set_dly(3, 0, 0, 0, 0, 0); b_resp_k = 2'b00;
      send(8'h21, 1'b1, 32'h100, 32'hDEADBEEF, 4'hF);
      wait_rsp(rsp_n + 1, 200, "t1_done");
      chk("t1_awaddr", last_awaddr, 32'h100);
      chk("t1_aw_hs", 32'(last_aw_n), 32'd1);
      chk("t1_w_hs", 32'(last_w_n), 32'd1);
      chk("t1_aw_cyc", 32'(last_aw_cyc - req_cyc[req_n-1]), 32'd4);
      chk("t1_w_cyc", 32'(last_w_cyc - req_cyc[req_n-1]), 32'd1);
      chk("t1_wdata", last_wdata, 32'hDEADBEEF);
      chk("t1_wstrb", 32'(last_wstrb), 32'hF);
      chk("t1_err", 32'(last_err), 32'd0);
      chk("t1_rdata", last_rdata, 32'd0);
      chk("t1_dst", 32'(last_dst), 32'h21);
      chk("t1_src", 32'(last_src), 32'h5A);
      chk("t1_we", 32'(last_we), 32'd1);

      // Read at an unaligned address
      set_dly(0, 0, 0, 0, 0, 0); r_data_k = 32'h12345678; r_resp_k = 2'b00;
      send(8'h33, 1'b0, 32'h103, 32'h0, 4'h0);
      wait_rsp(rsp_n + 1, 200, "t2_done");
      chk("t2_araddr", last_araddr, 32'h100);
      chk("t2_rdata", last_rdata, 32'h12345678);
      chk("t2_err", 32'(last_err), 32'd0);
      chk("t2_we", 32'(last_we), 32'd0);
      chk("t2_dst", 32'(last_dst), 32'h33);

      // Error responses
      r_data_k = 32'hCAFEF00D; r_resp_k = 2'b10;
      send(8'h44, 1'b0, 32'h2000, 32'h0, 4'h0);
      wait_rsp(rsp_n + 1, 200, "t3r_done");
      chk("t3r_err", 32'(last_err), 32'd1);
      chk("t3r_rdata", last_rdata, 32'hCAFEF00D);
      b_resp_k = 2'b11;
      send(8'h45, 1'b1, 32'h2004, 32'h11223344, 4'h3);
      wait_rsp(rsp_n + 1, 200, "t3w_done");
      chk("t3w_err", 32'(last_err), 32'd1);
      chk("t3w_rdata", last_rdata, 32'd0);
      b_resp_k = 2'b00; r_resp_k = 2'b00;

      // Response back-pressure with a second request queued behind it
      set_dly(0, 0, 0, 0, 0, 5);
      base = rsp_n; rq = req_n;
      send(8'h51, 1'b0, 32'h300, 32'h0, 4'h0);
      send(8'h52, 1'b0, 32'h304, 32'h0, 4'h0);
      wait_rsp(base + 2, 300, "t4_done");
      chk("t4_hold", 32'(last_hold), 32'd5);
      chk("t4_second_accept", 32'(req_cyc[rq+1] - rsp_cyc[base]), 32'd1);
      chk("t4_last_dst", 32'(last_dst), 32'h52);

      // Reset while waiting for the write response
      set_dly(0, 0, 0, 1000, 0, 0);
      send(8'h61, 1'b1, 32'h400, 32'h55AA55AA, 4'hF);
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!m_bready && k < 50);
      chk("t5_reach_wr_resp", 32'(m_bready), 32'd1);
      #2 res_n = 0;
      #1;
      chk_idle_outputs("t5");
      act = 0; mcount = '0; rsp_seen = 0; req_q.delete();
      base = rsp_n;
      repeat (3) @(posedge clk);
      @(negedge clk);
      #2 res_n = 1;
      b_dly = 0;
      repeat (10) @(negedge clk);
      chk("t5_no_rsp", 32'(rsp_n), 32'(base));

      // Zero-wait slave: AW/W together, B next cycle
      set_dly(0, 0, 0, 0, 0, 0);
      c0 = txn_count;
      send(8'h71, 1'b1, 32'h500, 32'h0BADF00D, 4'hC);
      wait_rsp(rsp_n + 1, 200, "t6w_done");
      chk("t6w_aw_w_same", 32'(last_aw_cyc - last_w_cyc), 32'd0);
      chk("t6w_latency", 32'(first_rsp_cyc - req_cyc[req_n-1]), 32'd3);
      chk("t6w_count", txn_count, c0 + 32'd1);
      send(8'h72, 1'b0, 32'h504, 32'h0, 4'h0);
      wait_rsp(rsp_n + 1, 200, "t6r_done");
      chk("t6r_latency", 32'(first_rsp_cyc - req_cyc[req_n-1]), 32'd3);

      // Randomized traffic
      rand_mode = 1; junk_en = 1;
      randomize_knobs();
      base = rsp_n;
      for (int i = 0; i < 80; i++) begin
         send(8'($urandom), 1'($urandom), $urandom, $urandom, 4'($urandom));
      end
      wait_rsp(base + 80, 6000, "rand_done");
      rand_mode = 0; junk_en = 0;
      repeat (3) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
